// File: rtl/spi_slave.sv
// SPI slave (sclk idles high, sample on rise, MSB first), fully in the clk domain.
// Optional input synchronisers; byte framing under ss, back-to-back bytes, frame error on early ss release.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic              s_sclk;
    logic              s_mosi;
    logic              s_ss;
    logic              prev_sclk;
    logic              prev_ss;
    logic              sclk_rise;
    logic              ss_fall;
    logic              ss_rise;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [BYTE_W-2:0] rx_sr;
    logic [BYTE_W-2:0] rx_sr_nxt;
    logic [BYTE_W-1:0] tx_sr;
    logic [BYTE_W-1:0] tx_sr_nxt;
    logic [BYTE_W-1:0] rx_data_nxt;
    logic              miso_oe_nxt;
    logic              tx_ready_nxt;
    logic              rx_valid_nxt;
    logic              frame_err_nxt;
    logic              busy_nxt;

    // Input conditioning: bypass when the master runs on clk, otherwise a flop chain per input
    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign s_sclk = sclk;
            assign s_mosi = mosi;
            assign s_ss   = ss;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sclk_q;
            logic [SYNC_STAGES-1:0] mosi_q;
            logic [SYNC_STAGES-1:0] ss_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sclk_q <= '1;
                    mosi_q <= '0;
                    ss_q   <= '1;
                end else begin
                    sclk_q <= SYNC_STAGES'({sclk_q, sclk});
                    mosi_q <= SYNC_STAGES'({mosi_q, mosi});
                    ss_q   <= SYNC_STAGES'({ss_q, ss});
                end
            end

            assign s_sclk = sclk_q[SYNC_STAGES-1];
            assign s_mosi = mosi_q[SYNC_STAGES-1];
            assign s_ss   = ss_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sclk <= 1'b1;
            prev_ss   <= 1'b1;
        end else begin
            prev_sclk <= s_sclk;
            prev_ss   <= s_ss;
        end
    end

    assign sclk_rise = s_sclk & ~prev_sclk;
    assign ss_fall   = ~s_ss & prev_ss;
    assign ss_rise   = s_ss & ~prev_ss;

    // miso is the MSB of the tx shift register, which is cleared whenever deselected
    assign miso = tx_sr[BYTE_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            rx_data   <= '0;
            miso_oe   <= 1'b0;
            tx_ready  <= 1'b1;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rx_sr     <= rx_sr_nxt;
            tx_sr     <= tx_sr_nxt;
            rx_data   <= rx_data_nxt;
            miso_oe   <= miso_oe_nxt;
            tx_ready  <= tx_ready_nxt;
            rx_valid  <= rx_valid_nxt;
            frame_err <= frame_err_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rx_sr_nxt     = rx_sr;
        tx_sr_nxt     = tx_sr;
        rx_data_nxt   = rx_data;
        miso_oe_nxt   = miso_oe;
        rx_valid_nxt  = 1'b0;
        frame_err_nxt = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                tx_sr_nxt   = '0;
                miso_oe_nxt = 1'b0;
                if (ss_fall) begin
                    state_nxt   = SHIFT;
                    tx_sr_nxt   = tx_data;
                    miso_oe_nxt = 1'b1;
                end
            end
            SHIFT: begin
                // ss release takes priority over a coincident sclk edge
                if (ss_rise) begin
                    state_nxt     = IDLE;
                    cnt_nxt       = '0;
                    tx_sr_nxt     = '0;
                    miso_oe_nxt   = 1'b0;
                    frame_err_nxt = (cnt != '0);
                end else if (sclk_rise) begin
                    cnt_nxt   = CNT_W'(cnt + 1'b1);
                    rx_sr_nxt = {rx_sr[BYTE_W-3:0], s_mosi};
                    if (cnt == CNT_W'(BYTE_W - 1)) begin
                        rx_data_nxt  = {rx_sr, s_mosi};
                        rx_valid_nxt = 1'b1;
                        tx_sr_nxt    = tx_data;
                    end else begin
                        tx_sr_nxt = {tx_sr[BYTE_W-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt     = (state_nxt == SHIFT);
        tx_ready_nxt = (state_nxt == IDLE) || (cnt_nxt == CNT_W'(BYTE_W - 1));
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, flops on sclk/mosi/ss before use; legal 0, 2, 3; 0 = direct sampling when the master shares clk.
REQ-002 clk  input  1  system clock; all logic on rising edge; the only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sclk  input  1  SPI clock; idles high.
REQ-005 mosi  input  1  serial data from master, MSB first.
REQ-006 ss  input  1  slave select, active-low.
REQ-007 miso  output  1  serial data to master, MSB first.
REQ-008 miso_oe  output  1  high while selected; miso is don't-care when low.
REQ-009 tx_data  input  8  byte to return in the next byte slot.
REQ-010 tx_ready  output  1  high when tx_data will be sampled at the next byte start.
REQ-011 rx_data  output  8  last complete received byte, held until the next byte completes.
REQ-012 rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-013 frame_err  output  1  one-cycle pulse, ss deasserted mid-byte.
REQ-014 busy  output  1  high while ss is asserted (after sync).

Function
REQ-015 Internal signals s_sclk, s_mosi, s_ss are the SYNC_STAGES-delayed inputs; all edge detection uses s_* against a one-flop previous copy.
REQ-016 sclk rise = s_sclk 1 and prev 0; ss fall and ss rise likewise.
REQ-017 States IDLE, SHIFT; IDLE->SHIFT on ss fall; SHIFT->IDLE on ss rise; no other transitions.
REQ-018 On ss fall: load tx shift register from tx_data, clear bit counter to 0, miso = tx_data[7], miso_oe = 1.
REQ-019 In SHIFT, on sclk rise: rx shift register = {rx[6:0], s_mosi}; tx register shifts left; miso takes the next bit in the same cycle, valid before the next sclk fall.
REQ-020 Bit counter 3-bit, increments on each sclk rise, wraps 7->0.
REQ-021 On the sclk rise taking the counter from 7 to 0: rx_data = {rx[6:0], s_mosi}; rx_valid pulses the next cycle; tx register reloads from tx_data; miso = tx_data[7].
REQ-022 Back-to-back bytes under a single ss assertion are supported without gaps; each byte produces exactly one rx_valid.
REQ-023 tx_ready high in IDLE and in SHIFT when counter = 7; low otherwise.
REQ-024 ss rise with counter = 0: clean end, no pulse; counter != 0: frame_err pulse, partial byte discarded, rx_data unchanged.
REQ-025 sclk edges while ss deasserted are ignored; miso_oe = 0, miso = 0 in IDLE.
REQ-026 ss rise and sclk rise in the same cycle: ss rise wins; the bit is not captured.
REQ-027 ss fall and sclk rise in the same cycle: load per REQ-018; the sclk edge is ignored.
REQ-028 Timing contract: with SYNC_STAGES = N > 0, each sclk level and ss high time is at least N+1 clk cycles; with N = 0, sclk may toggle every clk cycle (spi_master on the same clk).
REQ-029 No backpressure: an unread rx_data is overwritten by the next byte.

Reset
REQ-030 rst high at a clk edge forces: state IDLE, counter 0, miso 0, miso_oe 0, rx_data 8'h00, rx_valid 0, frame_err 0, busy 0, tx_ready 1, sync and prev flops to idle levels (sclk 1, ss 1, mosi 0).
REQ-031 rst mid-byte discards the partial byte with no rx_valid and no frame_err; the next ss fall starts a fresh byte.

Verification
REQ-032 SYNC_STAGES=0, spi_master on the same clk sends 8'hA5, tx_data=8'h3C -> rx_data=8'hA5 with one rx_valid; master data_out=8'h3C.
REQ-033 SYNC_STAGES=2, sclk half-period 4 clk, two bytes 8'h01, 8'h80 under one ss; tx_data changed between bytes from 8'hF0 to 8'h0F -> rx_valid twice with 8'h01 then 8'h80; miso carries F0 then 0F.
REQ-034 ss raised after 5 sclk rises -> frame_err pulses once, no rx_valid, rx_data keeps its previous value; the next full byte 8'h5A is received correctly.
REQ-035 sclk toggled while ss high -> no rx_valid, miso_oe 0, counter stays 0.
REQ-036 rst asserted after 3 bits, released, then full byte 8'hC3 -> outputs at reset values during rst; afterwards rx_data=8'hC3, no frame_err.
REQ-037 ss rise coincident with the 8th sclk rise -> frame_err pulses, no rx_valid.
